// File: rtl/npu_sparse_pkg.sv
// Shared sizes and scheduler state type
// for the sparse MAC match path.
package npu_sparse_pkg;

  localparam int PREFIX_SUM_SIZE = 8;
  localparam int MEM_SIZE = 64;
  localparam int SM_NUM =
    MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int SM_AW = $clog2(SM_NUM);
  localparam int PS_AW =
    $clog2(PREFIX_SUM_SIZE);
  localparam int CNT_W = $clog2(MEM_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    SCAN
  } sched_state_e;

endpackage

// File: rtl/sparse_lsb_enc.sv
// Lowest-set-bit encoder: mask -> idx, has_bit,
// onehot_last (exactly one bit set in mask).
module sparse_lsb_enc #(
  parameter int W = 8,
  parameter int AW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  output logic [AW-1:0] idx,
  output logic          has_bit,
  output logic          onehot_last
);

  // Walk high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) idx = AW'(i);
    end
  end

  assign has_bit = |mask;

  assign onehot_last = has_bit &&
    ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/sparse_match_sched.sv
// Per-match scheduler: ANDs IFM/filter maps per
// segment, emits lowest match first, end/done.
// Ports: clk_i, rst_ni, chunk_start_i,
//   rd_sparsemap_last_i/addr_o, ifm/filt maps,
//   pri_enc valid/ready/match_addr/end,
//   chunk_done_o, match_cnt_o, busy_o.
module sparse_match_sched #(
  parameter int PREFIX_SUM_SIZE =
    npu_sparse_pkg::PREFIX_SUM_SIZE,
  parameter int MEM_SIZE =
    npu_sparse_pkg::MEM_SIZE,
  parameter int SM_NUM =
    MEM_SIZE / PREFIX_SUM_SIZE,
  parameter int SM_AW = $clog2(SM_NUM),
  parameter int PS_AW = $clog2(PREFIX_SUM_SIZE),
  parameter int CNT_W = $clog2(MEM_SIZE) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       chunk_start_i,
  input  logic [SM_AW-1:0]           rd_sparsemap_last_i,
  output logic [SM_AW-1:0]           rd_sparsemap_addr_o,
  input  logic [PREFIX_SUM_SIZE-1:0] ifm_sparsemap_i,
  input  logic [PREFIX_SUM_SIZE-1:0] filt_sparsemap_i,
  output logic                       pri_enc_valid_o,
  input  logic                       pri_enc_ready_i,
  output logic [PS_AW-1:0]           pri_enc_match_addr_o,
  output logic                       pri_enc_end_o,
  output logic                       chunk_done_o,
  output logic [CNT_W-1:0]           match_cnt_o,
  output logic                       busy_o
);

  import npu_sparse_pkg::sched_state_e;
  import npu_sparse_pkg::IDLE;
  import npu_sparse_pkg::FETCH;
  import npu_sparse_pkg::LOAD;
  import npu_sparse_pkg::SCAN;

  sched_state_e state_q, state_d;
  logic [SM_AW-1:0] addr_q, addr_d;
  logic [PREFIX_SUM_SIZE-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PS_AW-1:0] lsb_idx;
  logic has_bit;
  logic onehot_last;
  logic in_scan;
  logic fire;
  logic seg_end;
  logic last_seg;

  sparse_lsb_enc #(
    .W  (PREFIX_SUM_SIZE),
    .AW (PS_AW)
  ) u_lsb_enc (
    .mask        (mask_q),
    .idx         (lsb_idx),
    .has_bit     (has_bit),
    .onehot_last (onehot_last)
  );

  // A restart pulse masks this cycle's
  // handshake and end so nothing leaks out.
  assign in_scan = state_q == SCAN;
  assign fire = in_scan && has_bit &&
    pri_enc_ready_i && !chunk_start_i;
  assign seg_end = in_scan && !chunk_start_i &&
    (!has_bit || (fire && onehot_last));
  assign last_seg =
    addr_q == rd_sparsemap_last_i;

  assign rd_sparsemap_addr_o = addr_q;
  assign pri_enc_valid_o =
    in_scan && has_bit && !chunk_start_i;
  assign pri_enc_match_addr_o = lsb_idx;
  assign pri_enc_end_o = seg_end;
  assign chunk_done_o = seg_end && last_seg;
  assign match_cnt_o = cnt_q;
  assign busy_o = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (chunk_start_i) begin
      state_d = FETCH;
      addr_d  = '0;
      mask_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        FETCH: state_d = LOAD;
        LOAD: begin
          mask_d  = ifm_sparsemap_i &
                    filt_sparsemap_i;
          state_d = SCAN;
        end
        SCAN: begin
          if (fire) begin
            mask_d = mask_q & (mask_q - 1'b1);
            if (cnt_q < CNT_W'(MEM_SIZE))
              cnt_d = cnt_q + 1'b1;
          end
          // Last segment keeps addr so the
          // downstream compare sees it.
          if (seg_end) begin
            if (last_seg) begin
              state_d = IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sparse_match_sched.sv
// Directed bench for sparse_match_sched with a
// 1-cycle registered sparsemap memory model.
module tb_sparse_match_sched;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] last;
  logic [2:0] rd_addr;
  logic [7:0] ifm_q;
  logic [7:0] filt_q;
  logic       valid;
  logic       ready;
  logic [2:0] match_addr;
  logic       end_p;
  logic       done;
  logic [6:0] cnt;
  logic       busy;

  logic [7:0] ifm_mem [8];
  logic [7:0] filt_mem [8];

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int end_cnt = 0;
  int done_cnt = 0;
  int b_hs, b_end, b_done;

  sparse_match_sched dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .chunk_start_i        (start),
    .rd_sparsemap_last_i  (last),
    .rd_sparsemap_addr_o  (rd_addr),
    .ifm_sparsemap_i      (ifm_q),
    .filt_sparsemap_i     (filt_q),
    .pri_enc_valid_o      (valid),
    .pri_enc_ready_i      (ready),
    .pri_enc_match_addr_o (match_addr),
    .pri_enc_end_o        (end_p),
    .chunk_done_o         (done),
    .match_cnt_o          (cnt),
    .busy_o               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifm_q  <= ifm_mem[rd_addr];
    filt_q <= filt_mem[rd_addr];
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (valid && ready) hs_cnt++;
      if (end_p) end_cnt++;
      if (done) done_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && busy)
      assert (int'(last) < 8)
      else $error("FAIL last out of range");
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc();
    #1;
  endtask

  // Leaves the bench in cycle 1 (FETCH).
  task automatic run_start();
    cyc();
    start = 1'b1;
    #1;
    check("idle_busy", 32'(busy), 0);
    cyc();
    start = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    last  = '0;
    for (int i = 0; i < 8; i++) begin
      ifm_mem[i]  = '0;
      filt_mem[i] = '0;
    end

    // async reset mid-clock
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_end", 32'(end_p), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(rd_addr), 0);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_maddr", 32'(match_addr), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) cyc();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_valid", 32'(valid), 0);

    // single segment: AND = 1001_0100
    ifm_mem[0]  = 8'b1011_0100;
    filt_mem[0] = 8'b1001_0110;
    last  = 3'd0;
    ready = 1'b1;
    run_start();
    check("s1_busy", 32'(busy), 1);
    check("s1_c1_valid", 32'(valid), 0);
    step();
    check("s1_c2_valid", 32'(valid), 0);
    step();
    check("s1_c3_valid", 32'(valid), 1);
    check("s1_c3_addr", 32'(match_addr), 2);
    check("s1_c3_end", 32'(end_p), 0);
    step();
    check("s1_c4_addr", 32'(match_addr), 4);
    check("s1_c4_end", 32'(end_p), 0);
    step();
    check("s1_c5_addr", 32'(match_addr), 7);
    check("s1_c5_end", 32'(end_p), 1);
    check("s1_c5_done", 32'(done), 1);
    step();
    check("s1_idle", 32'(busy), 0);
    check("s1_cnt", 32'(cnt), 3);
    check("s1_end_off", 32'(end_p), 0);

    // empty segment then single match
    ifm_mem[0]  = 8'h0F;
    filt_mem[0] = 8'hF0;
    ifm_mem[1]  = 8'h01;
    filt_mem[1] = 8'hFF;
    last = 3'd1;
    run_start();
    step();
    step();
    check("e_c3_end", 32'(end_p), 1);
    check("e_c3_valid", 32'(valid), 0);
    check("e_c3_done", 32'(done), 0);
    check("e_c3_raddr", 32'(rd_addr), 0);
    step();
    check("e_c4_raddr", 32'(rd_addr), 1);
    check("e_c4_end", 32'(end_p), 0);
    step();
    step();
    check("e_c6_valid", 32'(valid), 1);
    check("e_c6_addr", 32'(match_addr), 0);
    check("e_c6_end", 32'(end_p), 1);
    check("e_c6_done", 32'(done), 1);
    step();
    check("e_idle", 32'(busy), 0);
    check("e_cnt", 32'(cnt), 1);
    check("e_raddr_hold", 32'(rd_addr), 1);

    // backpressure: AND = 0010_1000
    ifm_mem[0]  = 8'h28;
    filt_mem[0] = 8'hFF;
    last = 3'd0;
    b_hs  = hs_cnt;
    b_end = end_cnt;
    run_start();
    step();
    cyc();
    ready = 1'b0;
    #1;
    check("bp_c3_valid", 32'(valid), 1);
    check("bp_c3_addr", 32'(match_addr), 3);
    cyc();
    #1;
    check("bp_c4_addr", 32'(match_addr), 3);
    check("bp_c4_mask", 32'(dut.mask_q), 32'h28);
    check("bp_c4_cnt", 32'(cnt), 0);
    cyc();
    ready = 1'b1;
    #1;
    check("bp_c5_addr", 32'(match_addr), 3);
    check("bp_c5_end", 32'(end_p), 0);
    step();
    check("bp_c6_addr", 32'(match_addr), 5);
    check("bp_c6_end", 32'(end_p), 1);
    check("bp_c6_done", 32'(done), 1);
    step();
    check("bp_idle", 32'(busy), 0);
    check("bp_cnt", 32'(cnt), 2);
    check("bp_hs", 32'(hs_cnt - b_hs), 2);
    check("bp_ends", 32'(end_cnt - b_end), 1);

    // abort during segment 2 of 4
    ifm_mem[0]  = 8'h01;
    filt_mem[0] = 8'hFF;
    ifm_mem[1]  = 8'h00;
    filt_mem[1] = 8'h00;
    ifm_mem[2]  = 8'h06;
    filt_mem[2] = 8'hFF;
    ifm_mem[3]  = 8'h00;
    filt_mem[3] = 8'h00;
    last = 3'd3;
    b_done = done_cnt;
    run_start();
    step();
    step();
    check("ab_c3_end", 32'(end_p), 1);
    check("ab_c3_done", 32'(done), 0);
    step();
    check("ab_c4_raddr", 32'(rd_addr), 1);
    step();
    step();
    check("ab_c6_end", 32'(end_p), 1);
    check("ab_c6_valid", 32'(valid), 0);
    step();
    check("ab_c7_raddr", 32'(rd_addr), 2);
    step();
    step();
    check("ab_c9_addr", 32'(match_addr), 1);
    check("ab_c9_cnt", 32'(cnt), 1);
    cyc();
    start = 1'b1;
    #1;
    check("ab_c10_end", 32'(end_p), 0);
    check("ab_c10_done", 32'(done), 0);
    check("ab_c10_valid", 32'(valid), 0);
    cyc();
    start = 1'b0;
    #1;
    check("ab_c11_busy", 32'(busy), 1);
    check("ab_c11_raddr", 32'(rd_addr), 0);
    check("ab_c11_cnt", 32'(cnt), 0);
    check("ab_c11_mask", 32'(dut.mask_q), 0);
    check("ab_no_done", 32'(done_cnt - b_done), 0);

    // async reset while a match is presented
    step();
    cyc();
    ready = 1'b0;
    #1;
    check("ar_valid_pre", 32'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(valid), 0);
    check("ar_end", 32'(end_p), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_cnt", 32'(cnt), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) cyc();
    check("ar_idle", 32'(busy), 0);
    check("ar_idle_valid", 32'(valid), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/sparse_match_sched.md
Name: sparse_match_sched

Overview:
- Generates the per-match stream that drives the IFM input-select stage of the sparse MAC datapath.
- Walks the sparsemap segments of one chunk, ANDs the IFM and filter sparsemaps, and emits one matching bit position per handshake, lowest bit first.
- Signals segment end so the downstream base address advances, and chunk end so the next chunk can start.

Parameters:
- PREFIX_SUM_SIZE, default 8: bits per sparsemap segment.
- MEM_SIZE, default 64: IFM entries per chunk buffer.
- SM_NUM, derived as MEM_SIZE/PREFIX_SUM_SIZE: segments per chunk.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset. One clock; reset is asynchronous and active-low.
- chunk_start_i, in, 1: pulse that starts, or restarts, chunk processing.
- rd_sparsemap_last_i, in, $clog2(SM_NUM): index of the last valid segment.
- rd_sparsemap_addr_o, out, $clog2(SM_NUM): segment address to the IFM and filter sparsemap memories.
- ifm_sparsemap_i, in, PREFIX_SUM_SIZE: IFM sparsemap segment (1-cycle read latency).
- filt_sparsemap_i, in, PREFIX_SUM_SIZE: filter sparsemap segment (same latency).
- pri_enc_valid_o, out, 1: a match is presented.
- pri_enc_ready_i, in, 1: the consumer accepts the match.
- pri_enc_match_addr_o, out, $clog2(PREFIX_SUM_SIZE): bit position of the match within the segment.
- pri_enc_end_o, out, 1: pulse marking the last event of the current segment.
- chunk_done_o, out, 1: pulse on the end of the last segment.
- match_cnt_o, out, $clog2(MEM_SIZE)+1: number of matches accepted in the current chunk.
- busy_o, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output and internal register is 0.
- FSM states: IDLE, FETCH, LOAD, SCAN.
  - IDLE: on chunk_start_i, go to FETCH with addr=0 and match_cnt=0.
  - FETCH: address is stable; the memories register their outputs. Go to LOAD next cycle.
  - LOAD: capture mask_r = ifm_sparsemap_i & filt_sparsemap_i. Go to SCAN.
  - SCAN, mask_r==0: assert pri_enc_end_o for 1 cycle with valid=0. This covers empty segments; the downstream stage still needs the end pulse to advance its base.
  - SCAN, mask_r!=0: valid=1 and match_addr = index of the lowest set bit.
    - On valid&&ready: clear that bit and increment match_cnt.
    - If the cleared bit was the only set bit, assert pri_enc_end_o in the same cycle.
  - End handling: when pri_enc_end_o is high, check the segment address.
    - If addr==last: assert chunk_done_o in the same cycle and go to IDLE. addr stays put, so the downstream last-segment compare sees a match on that cycle.
    - Otherwise: addr increments at that edge and the FSM goes to FETCH.
- Address hold: rd_sparsemap_addr_o is held throughout SCAN, so the IFM sparsemap input stays valid for the downstream prefix sum.
- Latency: chunk_start_i in cycle 0 gives FETCH in cycle 1, LOAD in cycle 2, and the first valid or end in cycle 3. Each later segment adds 2 bubble cycles.
- Backpressure: while valid&&!ready, match_addr_o, mask_r and addr are frozen.
- Pulse widths: pri_enc_end_o and chunk_done_o are single-cycle. They never assert without SCAN.
- chunk_start_i in any non-IDLE state: abort immediately. Set addr=0, clear mask_r and match_cnt, go to FETCH. No end or done pulse is emitted. chunk_start_i has priority over a simultaneous handshake or end.
- match_cnt_o: saturates at MEM_SIZE; it cannot exceed this by construction. Holds its value in IDLE until the next chunk_start_i.
- rd_sparsemap_last_i: sampled continuously and must be stable while busy_o is high. A value >= SM_NUM is illegal; the bench asserts on it.

Decomposition:
- Package npu_sparse_pkg holds:
  - PREFIX_SUM_SIZE, MEM_SIZE, SM_NUM and the derived widths.
  - The sched_state_e enum {IDLE, FETCH, LOAD, SCAN}.
- Sub-module sparse_lsb_enc (combinational). Input: the mask. Outputs: lowest-set index, an any flag, and onehot_last (exactly one bit set). Reused by later filter-side schedulers.

Test Plan:
- Reset: assert rst_ni low mid-clock -> all outputs 0 asynchronously. After release with no chunk_start_i, the block stays IDLE and busy_o=0.
- Single segment: last=0, ifm=8'b1011_0100, filt=8'b1001_0110, ready=1 -> matches 2,4,7 in cycles 3,4,5. end_o and chunk_done_o assert in cycle 5; match_cnt_o=3.
- Empty segment: last=1, segment 0 AND=0 -> cycle 3 has end_o=1 with valid=0, and addr becomes 1. Segment 1 AND=8'h01 -> match 0 in cycle 6 with end_o and chunk_done_o.
- Backpressure: 2-match segment, ready low for 2 cycles on the first match -> match_addr_o is stable and mask_r unchanged. Exactly 2 handshakes occur and end_o asserts once.
- Abort: chunk_start_i during SCAN of segment 2 (last=3) -> next cycle is FETCH with addr=0 and match_cnt_o=0. No chunk_done_o is emitted.
- Async reset mid-SCAN: rst_ni low with valid=1 -> valid, end and busy drop to 0 immediately. After release the block is IDLE.
